// File: rtl/microsequencer.sv
// Next-state stage of the microprogrammed control unit: picks the next microstore
// address from the control-register fields and status inputs, with a return stack for microsubroutines.
module microsequencer #(
  parameter int ADDR_W      = 10,
  parameter int FETCH_ADDR  = 1,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       N,
  input  logic                             inv,
  input  logic [1:0]                       select,
  input  logic [5:0]                       cr,
  input  logic [ADDR_W-1:0]                decode_addr,
  input  logic                             mfc,
  input  logic                             cond_true,
  input  logic                             ir_bit,
  output logic [ADDR_W-1:0]                next_state,
  output logic                             stack_err,
  output logic [$clog2(STACK_DEPTH):0]     stack_level
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] OP_DECODE = 3'd0;
  localparam logic [2:0] OP_FETCH  = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_INC    = 3'd4;
  localparam logic [2:0] OP_CALL   = 3'd5;
  localparam logic [2:0] OP_RET    = 3'd6;
  localparam logic [2:0] OP_WAIT   = 3'd7;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] cr_ext;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] nxt;
  logic [PTR_W-1:0]  top_idx;
  logic              sel_sig;
  logic              cond;
  logic              stack_full;
  logic              stack_empty;
  logic              push;
  logic              pop;
  logic              err_set;

  assign incr        = next_state + ADDR_W'(1);
  assign cr_ext      = ADDR_W'(cr);
  assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
  assign stack_empty = (stack_level == '0);
  assign top_idx     = PTR_W'(stack_level - LVL_W'(1));
  assign stack_top   = stack_mem[top_idx];

  // select=3 feeds a constant 0, so inv turns it into an unconditional true.
  always_comb begin
    sel_sig = 1'b0;
    case (select)
      2'd0: sel_sig = mfc;
      2'd1: sel_sig = cond_true;
      2'd2: sel_sig = ir_bit;
      2'd3: sel_sig = 1'b0;
    endcase
    cond = sel_sig ^ inv;
  end

  always_comb begin
    nxt     = next_state;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (N)
      OP_DECODE: nxt = decode_addr;
      OP_FETCH:  nxt = ADDR_W'(FETCH_ADDR);
      OP_JUMP:   nxt = cr_ext;
      OP_BRANCH: nxt = cond ? cr_ext : incr;
      OP_INC:    nxt = incr;
      OP_CALL: begin
        nxt = cr_ext;
        if (stack_full) err_set = 1'b1;
        else            push    = 1'b1;
      end
      // Returning with nothing on the stack aborts the instruction back to fetch.
      OP_RET: begin
        if (stack_empty) begin
          nxt     = ADDR_W'(FETCH_ADDR);
          err_set = 1'b1;
        end else begin
          nxt = stack_top;
          pop = 1'b1;
        end
      end
      OP_WAIT:   nxt = cond ? incr : next_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_state  <= ADDR_W'(RESET_ADDR);
      stack_level <= '0;
      stack_err   <= 1'b0;
    end else begin
      next_state <= nxt;
      if (push)    stack_level <= stack_level + LVL_W'(1);
      else if (pop) stack_level <= stack_level - LVL_W'(1);
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Contents need no reset; an empty level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) stack_mem[stack_level[PTR_W-1:0]] <= incr;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus random
// stimulus compared against a queue-based behavioural model.
module tb_microsequencer;

  localparam int DEPTH = 4;
  localparam int FETCH = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] N;
  logic       inv;
  logic [1:0] select;
  logic [5:0] cr;
  logic [9:0] decode_addr;
  logic       mfc;
  logic       cond_true;
  logic       ir_bit;
  logic [9:0] next_state;
  logic       stack_err;
  logic [2:0] stack_level;

  int checks   = 0;
  int failures = 0;

  int m_state;
  bit m_err;
  int m_stack[$];

  microsequencer #(
    .ADDR_W(10), .FETCH_ADDR(FETCH), .RESET_ADDR(0), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .N(N), .inv(inv), .select(select), .cr(cr),
    .decode_addr(decode_addr), .mfc(mfc), .cond_true(cond_true), .ir_bit(ir_bit),
    .next_state(next_state), .stack_err(stack_err), .stack_level(stack_level)
  );

  always #5 clk = ~clk;

  // Applies one control word, advances the model, and waits past the active edge.
  task automatic drive(input logic [2:0] n, input logic iv, input logic [1:0] sl,
                       input logic [5:0] c, input logic [9:0] dec,
                       input logic m, input logic ct, input logic ib);
    bit sig, take;
    int incr;
    N = n; inv = iv; select = sl; cr = c; decode_addr = dec;
    mfc = m; cond_true = ct; ir_bit = ib;
    sig  = (sl == 0) ? m : (sl == 1) ? ct : (sl == 2) ? ib : 1'b0;
    take = sig ^ iv;
    incr = (m_state + 1) % 1024;
    case (n)
      0: m_state = dec;
      1: m_state = FETCH;
      2: m_state = c;
      3: m_state = take ? int'(c) : incr;
      4: m_state = incr;
      5: begin
        if (m_stack.size() == DEPTH) m_err = 1;
        else m_stack.push_back(incr);
        m_state = c;
      end
      6: begin
        if (m_stack.size() == 0) begin
          m_err = 1;
          m_state = FETCH;
        end else m_state = m_stack.pop_back();
      end
      7: m_state = take ? incr : m_state;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    m_state = 0; m_err = 0; m_stack.delete();
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(2, 0, 0, 6'd10, 0, 0, 0, 0);
    drive(5, 0, 0, 6'd20, 0, 0, 0, 0);
    drive(5, 0, 0, 6'd37, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd37 || stack_level !== 3'd2) begin
      failures++;
      $display("[TB] FAIL reset_setup: got state=%0d level=%0d, want 37/2", next_state, stack_level);
    end
    #2 reset = 1'b1;
    m_state = 0; m_err = 0; m_stack.delete();
    #1;
    checks++;
    if (next_state !== 10'd0 || stack_level !== 3'd0 || stack_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: got state=%0d level=%0d err=%0b, want 0/0/0",
               next_state, stack_level, stack_err);
    end
    #1 reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd1) begin
      failures++;
      $display("[TB] FAIL reset_fetch: got %0d, want 1", next_state);
    end
  endtask

  task automatic test_sequencing();
    int exp_seq[4] = '{2, 3, 20, 45};
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'(exp_seq[0])) begin
      failures++; $display("[TB] FAIL seq_inc1: got %0d, want %0d", next_state, exp_seq[0]);
    end
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'(exp_seq[1])) begin
      failures++; $display("[TB] FAIL seq_inc2: got %0d, want %0d", next_state, exp_seq[1]);
    end
    drive(0, 0, 0, 0, 10'd20, 0, 0, 0);
    checks++;
    if (next_state !== 10'(exp_seq[2])) begin
      failures++; $display("[TB] FAIL seq_decode: got %0d, want %0d", next_state, exp_seq[2]);
    end
    drive(2, 0, 0, 6'd45, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'(exp_seq[3])) begin
      failures++; $display("[TB] FAIL seq_jump: got %0d, want %0d", next_state, exp_seq[3]);
    end
  endtask

  task automatic test_conditional();
    drive(3, 0, 2'd1, 6'd12, 0, 0, 1, 0);
    checks++;
    if (next_state !== 10'd12) begin
      failures++; $display("[TB] FAIL branch_taken: got %0d, want 12", next_state);
    end
    drive(3, 1, 2'd1, 6'd12, 0, 0, 1, 0);
    checks++;
    if (next_state !== 10'd13) begin
      failures++; $display("[TB] FAIL branch_inv: got %0d, want 13", next_state);
    end
    drive(3, 1, 2'd3, 6'd50, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd50) begin
      failures++; $display("[TB] FAIL branch_always: got %0d, want 50", next_state);
    end
    drive(3, 0, 2'd2, 6'd7, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd51) begin
      failures++; $display("[TB] FAIL branch_irbit: got %0d, want 51", next_state);
    end
  endtask

  task automatic test_wait();
    drive(2, 0, 0, 6'd8, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(7, 0, 2'd0, 0, 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'd8) begin
        failures++; $display("[TB] FAIL wait_hold%0d: got %0d, want 8", i, next_state);
      end
    end
    drive(7, 0, 2'd0, 0, 0, 1, 0, 0);
    checks++;
    if (next_state !== 10'd9) begin
      failures++; $display("[TB] FAIL wait_release: got %0d, want 9", next_state);
    end
  endtask

  task automatic test_subroutine();
    int exp_state[4] = '{30, 40, 31, 11};
    int exp_lvl[4]   = '{1, 2, 1, 0};
    logic [2:0] ops[4] = '{3'd5, 3'd5, 3'd6, 3'd6};
    logic [5:0] tgt[4] = '{6'd30, 6'd40, 6'd0, 6'd0};
    drive(2, 0, 0, 6'd10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 0, 0, tgt[i], 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'(exp_state[i]) || stack_level !== 3'(exp_lvl[i]) || stack_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sub_step%0d: got state=%0d level=%0d err=%0b, want %0d/%0d/0",
                 i, next_state, stack_level, stack_err, exp_state[i], exp_lvl[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    for (int i = 0; i < 5; i++) drive(5, 0, 0, 6'(10 + i * 5), 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd30 || stack_level !== 3'd4 || stack_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow: got state=%0d level=%0d err=%0b, want 30/4/1",
               next_state, stack_level, stack_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(6, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'(m_state) || stack_level !== 3'(m_stack.size())) begin
        failures++;
        $display("[TB] FAIL unwind%0d: got state=%0d level=%0d, want %0d/%0d",
                 i, next_state, stack_level, m_state, m_stack.size());
      end
    end
    do_reset();
    drive(6, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd1 || stack_err !== 1'b1 || stack_level !== 3'd0) begin
      failures++;
      $display("[TB] FAIL underflow: got state=%0d err=%0b level=%0d, want 1/1/0",
               next_state, stack_err, stack_level);
    end
    drive(0, 0, 0, 0, 10'd1023, 0, 0, 0);
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd0) begin
      failures++; $display("[TB] FAIL wrap: got %0d, want 0", next_state);
    end
    drive(0, 0, 0, 0, 10'd1023, 0, 0, 0);
    drive(5, 0, 0, 6'd5, 0, 0, 0, 0);
    drive(6, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd0) begin
      failures++; $display("[TB] FAIL call_wrap: got %0d, want 0", next_state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 64 == 0) do_reset();
      drive(3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 6'($urandom),
            10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (next_state !== 10'(m_state) || stack_level !== 3'(m_stack.size()) || stack_err !== m_err) begin
        failures++;
        $display("[TB] FAIL random%0d: got state=%0d level=%0d err=%0b, want %0d/%0d/%0b",
                 i, next_state, stack_level, stack_err, m_state, m_stack.size(), m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    N = 0; inv = 0; select = 0; cr = 0; decode_addr = 0;
    mfc = 0; cond_true = 0; ir_bit = 0;
    m_state = 0; m_err = 0;
    @(posedge clk);
    #1;
    #3 reset = 1'b0;
    test_reset();
    test_sequencing();
    test_conditional();
    test_wait();
    test_subroutine();
    test_boundaries();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Upstream next-state stage of the microprogrammed control unit.
- Takes the N, inv, select and cr fields from the control register, plus status inputs, and computes the next microstore address.
- Registers that address and drives it as next_state into the microstore; the microstore output is then latched by the control register.
- Contains the state register, incrementer, condition multiplexer/inverter and a small microsubroutine return stack.

Parameters:
ADDR_W, 10, width of the microstore address (next_state)
FETCH_ADDR, 1, microstore address of the first fetch state
RESET_ADDR, 0, address loaded on reset
STACK_DEPTH, 4, microsubroutine return-stack entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
N  in  3  next-state operation, from control register
inv  in  1  invert selected condition, from control register
select  in  2  condition source select, from control register
cr  in  6  branch target, from control register; zero-extended to ADDR_W
decode_addr  in  ADDR_W  first state of the decoded instruction, from instruction encoder
mfc  in  1  memory function complete
cond_true  in  1  IR condition field satisfied by the status flags
ir_bit  in  1  IR qualifier bit (immediate/load-store direction)
next_state  out  ADDR_W  registered microstore address
stack_err  out  1  sticky stack overflow/underflow flag
stack_level  out  log2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-subroutine):
  - next_state=RESET_ADDR, stack emptied, stack_level=0, stack_err=0.
- Condition:
  - sel_sig = mfc/cond_true/ir_bit/1'b0 for select=0/1/2/3.
  - C = sel_sig ^ inv; select=3 with inv=1 gives an unconditional true.
- incr = next_state+1, modulo 2^ADDR_W; wraps from max to 0.
- All updates occur on the rising clk edge. next_state is the registered value, so there is 1 cycle of latency from N/cr to the new address.
- N encoding:
  - 0 DECODE: next=decode_addr.
  - 1 FETCH: next=FETCH_ADDR.
  - 2 JUMP: next=cr.
  - 3 BRANCH: next = C ? cr : incr.
  - 4 INC: next=incr.
  - 5 CALL: push incr; next=cr.
  - 6 RET: pop; next=popped value.
  - 7 WAIT: next = C ? incr : next_state (hold). Used with select=0 to stall until mfc.
- Stack is LIFO: stack_level increments on a successful push and decrements on a successful pop.
- CALL with stack_level==STACK_DEPTH:
  - No push; stack contents unchanged.
  - stack_err←1; next=cr still taken.
- RET with stack_level==0:
  - next=FETCH_ADDR (instruction aborted).
  - stack_err←1.
- stack_err is sticky; it is cleared only by reset.
- Only one N is processed per cycle; there are no simultaneous push/pop cases.
- Unknown or X inputs are not handled specially.

Test Plan:
- Reset: assert reset mid-cycle with next_state=37, stack_level=2 → immediately next_state=0, stack_level=0, stack_err=0. Release reset, then N=1 → next_state=1 after 1 edge.
- Sequencing: N=4 from 1 → 2 → 3. N=0 with decode_addr=20 → next_state=20. N=2 with cr=6'd45 → next_state=45.
- Conditional:
  - N=3, select=1, cond_true=1, inv=0, cr=12 → 12.
  - Same with inv=1 → incr.
  - select=3, inv=1 → always cr.
- WAIT:
  - next_state=8, N=7, select=0, mfc=0 for 3 edges → stays 8.
  - mfc=1 → 9 on the next edge.
- Subroutine:
  - From 10, CALL cr=30 → 30, stack_level=1.
  - From 30, CALL cr=40 → 40, stack_level=2.
  - RET → 31; RET → 11; stack_level=0, stack_err=0.
- Boundaries:
  - 5 CALLs with STACK_DEPTH=4 → stack_level=4, stack_err=1, 5th target still taken.
  - RET on empty stack → next_state=1, stack_err=1.
  - N=4 at next_state=1023 → 0.
